// File: rtl/uparc_long_idiv.sv
`timescale 1ns/1ps
// uparc_long_idiv
//   Multi-cycle restoring divider for MIPS DIV/DIVU. It produces one quotient
//   bit per clock over 32 iterations. It divides the operand magnitudes and
//   corrects the signs of the quotient and remainder at the output.
//
// Ports
//   clk       : clock
//   nrst      : asynchronous active-low reset
//   dividend  : numerator, sampled in the start cycle
//   divisor   : denominator, sampled in the start cycle
//   start     : one-cycle launch pulse; asserting it while busy restarts the unit
//   signd     : 1 = signed (DIV), 0 = unsigned (DIVU), sampled with start
//   ready     : result valid and unit idle (= !busy && !start)
//   quotient  : result quotient, held until the next start
//   remainder : result remainder, held until the next start
//
// Optional feature
//   UPARC_IDIV_ZERO_SHORTCUT_EN : when defined, a zero dividend or a zero
//   divisor completes in the start cycle instead of taking 32 iterations.
//   The results are identical either way.
module uparc_long_idiv (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        start,
  input  logic        signd,
  output logic        ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned W = 32;

  logic [5:0]   nbit;
  logic [W-1:0] rem;
  logic [W-1:0] quo;
  logic [W-1:0] abs_div;
  logic         neg_q;
  logic         neg_r;
  logic         dz;

  logic         busy;
  logic [W-1:0] abs_dvd;
  logic [W-1:0] abs_dvs;
  logic [W:0]   shifted;
  logic [W:0]   trial;

  // The partial remainder always stays below abs_div, so 32 bits of storage
  // are enough. The 33-bit trial result still shows the borrow.
  always_comb begin
    busy    = (nbit != 6'd0);
    abs_dvd = (signd && dividend[W-1]) ? -dividend : dividend;
    abs_dvs = (signd && divisor[W-1])  ? -divisor  : divisor;
    shifted = {rem, quo[W-1]};
    trial   = shifted - {1'b0, abs_div};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nbit    <= '0;
      rem     <= '0;
      quo     <= '0;
      abs_div <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
    end else if (start) begin
      quo     <= abs_dvd;
      abs_div <= abs_dvs;
      // For a division by zero, rem holds the raw dividend as the final remainder.
      rem     <= (divisor == '0) ? dividend : '0;
      nbit    <= 6'd32;
      neg_q   <= signd & (dividend[W-1] ^ divisor[W-1]);
      neg_r   <= signd & dividend[W-1];
      dz      <= (divisor == '0);
`ifdef UPARC_IDIV_ZERO_SHORTCUT_EN
      if (dividend == '0 || divisor == '0) begin
        nbit <= '0;
        quo  <= '0;
      end
`endif
    end else if (busy) begin
      nbit <= nbit - 6'd1;
      // After a division by zero the registers stay frozen, so rem keeps the
      // raw dividend through the full-length run.
      if (!dz) begin
        if (!trial[W]) begin
          rem <= trial[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= shifted[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    ready = !busy && !start;
    if (dz) begin
      quotient  = '1;
      remainder = rem;
    end else begin
      quotient  = neg_q ? -quo : quo;
      remainder = neg_r ? -rem : rem;
    end
  end

endmodule
